// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package regfile_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned REG_DW   = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned CSUM_IDX = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    READ  = 3'd2,
    HOLD  = 3'd3,
    CSUM  = 3'd4
  } state_e;

endpackage

// File: rtl/regdump_out_stage.sv
// Valid/ready holding register (no skid): load, hold while stalled, clear on
// handshake or flush. Reusable on other debug streams.
module regdump_out_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_data_i,
  input  logic [AW-1:0] load_idx_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] idx_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [AW-1:0] idx_q;

  // Word register: flush drops the word, load replaces it, handshake retires it.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
      idx_q   <= load_idx_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks FIRST_REG..LAST_REG over the regfile read
// port and streams (index, data) words on a valid/ready interface.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR checksum word
// (index 0) after the last register.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int unsigned DW        = REG_DW,
  parameter int unsigned AW        = REG_AW,
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rn,
  input  logic [DW-1:0] qd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] rn_q;
  logic          busy_q;
  logic          done_q;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] acc_q;
`endif

  logic          fire_c;
  logic          abort_c;
  logic          last_c;
  logic          ld_c;
  logic [DW-1:0] ld_data_c;
  logic [AW-1:0] ld_idx_c;

  assign fire_c  = out_valid && out_ready;
  assign abort_c = abort && (state_q != IDLE);
  assign last_c  = (cnt_q == AW'(LAST_REG));

  // Output-stage load control: register words in READ, checksum after the last word.
  always_comb begin
    ld_c      = 1'b0;
    ld_data_c = qd;
    ld_idx_c  = cnt_q;
    if (!abort_c && state_q == READ) begin
      ld_c = 1'b1;
    end
`ifdef REGDUMP_CHECKSUM_EN
    if (!abort_c && state_q == HOLD && fire_c && last_c) begin
      ld_c      = 1'b1;
      ld_data_c = acc_q;
      ld_idx_c  = AW'(CSUM_IDX);
    end
`endif
  end

  regdump_out_stage #(
    .DW (DW),
    .AW (AW)
  ) u_out (
    .clk         (clk),
    .clr_i       (clr),
    .flush_i     (abort_c),
    .load_i      (ld_c),
    .load_data_i (ld_data_c),
    .load_idx_i  (ld_idx_c),
    .ready_i     (out_ready),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .idx_o       (out_idx)
  );

  // Dump sequencer: state, register counter, read address, busy and done.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rn_q    <= AW'(REG_ZERO);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= AW'(FIRST_REG);
            state_q <= SETUP;
            busy_q  <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        SETUP: begin
          rn_q    <= cnt_q;
          state_q <= READ;
        end
        READ: begin
          rn_q    <= AW'(REG_ZERO);
          state_q <= HOLD;
`ifdef REGDUMP_CHECKSUM_EN
          acc_q   <= acc_q ^ qd;
`endif
        end
        HOLD: begin
          if (fire_c) begin
            if (last_c) begin
`ifdef REGDUMP_CHECKSUM_EN
              state_q <= CSUM;
`else
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              cnt_q   <= cnt_q + AW'(1);
              state_q <= SETUP;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (fire_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Abort overrides any transition above, including a final handshake.
      if (abort_c) begin
        state_q <= IDLE;
        rn_q    <= AW'(REG_ZERO);
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end
    end
  end

  assign rn   = rn_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: full dumps, random back-pressure,
// abort, mid-dump clear and a single-register configuration.
module tb_regfile_dump_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          clr, start0, start1, abort, out_ready;
  logic [AW-1:0] rn0, rn1, i0, i1;
  logic [DW-1:0] qd0, qd1, d0, d1;
  logic          v0, v1, b0, b1, dn0, dn1;
  logic [DW-1:0] regs [32];

  bit            sel;
  logic          m_valid, m_busy, m_done;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_idx;

  int     n_assert = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  word_t  exp_q[$];

  always #5 clk = ~clk;

  assign qd0 = regs[rn0];
  assign qd1 = regs[rn1];

  assign m_valid = sel ? v1  : v0;
  assign m_busy  = sel ? b1  : b0;
  assign m_done  = sel ? dn1 : dn0;
  assign m_data  = sel ? d1  : d0;
  assign m_idx   = sel ? i1  : i0;

  regfile_dump_reader #(.DW(DW), .AW(AW), .FIRST_REG(1), .LAST_REG(31)) dut0 (
    .clk(clk), .clr(clr), .start(start0), .abort(abort), .rn(rn0), .qd(qd0),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_idx(i0),
    .busy(b0), .done(dn0)
  );

  regfile_dump_reader #(.DW(DW), .AW(AW), .FIRST_REG(5), .LAST_REG(5)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .abort(abort), .rn(rn1), .qd(qd1),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_idx(i1),
    .busy(b1), .done(dn1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference stream: every register in range in ascending order, plus XOR word when enabled.
  task automatic build_expected(input int first, input int last);
    logic [DW-1:0] acc;
    acc = '0;
    exp_q.delete();
    for (int k = first; k <= last; k++) begin
      exp_q.push_back('{idx: AW'(k), data: regs[k]});
      acc = acc ^ regs[k];
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back('{idx: AW'(0), data: acc});
`endif
  endtask

  // Consume words until done, checking order, data, stall stability and period.
  task automatic run_dump(input bit rand_ready, input int budget);
    bit            seen_done = 1'b0;
    bit            pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [AW-1:0] pi = '0;
    int            last_hs = -1;
    word_t         w;
    for (int n = 0; n < budget && !seen_done; n++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_idx", 64'(m_idx), 64'(pi));
        chk("hold_data", 64'(m_data), 64'(pd));
      end
      if (m_done) begin
        seen_done = 1'b1;
        chk("busy_at_done", 64'(m_busy), 64'd0);
        chk("words_left_at_done", 64'(exp_q.size()), 64'd0);
      end else if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word_idx", 64'(m_idx), 64'hFFFF);
        end else begin
          w = exp_q.pop_front();
          chk("word_idx", 64'(m_idx), 64'(w.idx));
          chk("word_data", 64'(m_data), 64'(w.data));
        end
        if (!rand_ready && m_idx != '0 && last_hs >= 0)
          chk("word_period", 64'(cyc - last_hs), 64'd3);
        if (m_idx != '0) last_hs = cyc;
      end
      pv = m_valid; pr = out_ready; pd = m_data; pi = m_idx;
      if (!seen_done) step();
    end
    chk("done_seen", 64'(seen_done), 64'd1);
  endtask

  initial begin
    bit found;
    int expk;

    clr = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; out_ready = 1'b0; sel = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = '0;
    step(); step();
    chk("rst_rn", 64'(rn0), 64'd0);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_data", 64'(d0), 64'd0);
    chk("rst_idx", 64'(i0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_done", 64'(dn0), 64'd0);
    chk("rst_valid1", 64'(v1), 64'd0);
    clr = 1'b0;
    step();

    // Pattern dump, latency and steady-state period.
    for (int k = 1; k < 32; k++) regs[k] = DW'(k) * 32'h11111111;
    build_expected(1, 31);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("lat_busy", 64'(b0), 64'd1);
    chk("lat_valid_c1", 64'(v0), 64'd0);
    step();
    chk("lat_valid_c2", 64'(v0), 64'd0);
    chk("lat_rn_read", 64'(rn0), 64'd1);
    step();
    chk("lat_valid_c3", 64'(v0), 64'd1);
    chk("lat_idx", 64'(i0), 64'd1);
    chk("lat_data", 64'(d0), 64'h11111111);
    chk("lat_rn_hold", 64'(rn0), 64'd0);
    run_dump(1'b0, 300);

    // Start in the done cycle is honoured.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("done_one_cycle", 64'(dn0), 64'd0);
    chk("start_at_done", 64'(b0), 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_after_restart", 64'(b0), 64'd0);

    // Random contents under random back-pressure.
    for (int k = 1; k < 32; k++) regs[k] = $urandom;
    build_expected(1, 31);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    run_dump(1'b1, 3000);
    step();

    // Abort while idx 7 is held, then a fresh dump from idx 1.
    out_ready = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (v0 && i0 == AW'(7)) begin
        found = 1'b1;
        out_ready = 1'b0;
      end else begin
        step();
      end
    end
    chk("abort_reached_idx7", 64'(found), 64'd1);
    step();
    chk("abort_held_valid", 64'(v0), 64'd1);
    chk("abort_held_idx", 64'(i0), 64'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 64'(v0), 64'd0);
    chk("abort_busy", 64'(b0), 64'd0);
    chk("abort_rn", 64'(rn0), 64'd0);
    chk("abort_done", 64'(dn0), 64'd0);
    step();
    chk("abort_no_done_later", 64'(dn0), 64'd0);
    build_expected(1, 31);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    run_dump(1'b0, 300);
    step();

    // Start held high while busy must not restart; clear during SETUP of idx 12.
    out_ready = 1'b1;
    start0 = 1'b1;
    expk = 1;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (v0) begin
        chk("busy_start_order", 64'(i0), 64'(expk));
        if (i0 == AW'(11)) found = 1'b1;
        expk++;
      end
      step();
    end
    chk("clr_reached_setup12", 64'(found), 64'd1);
    chk("setup12_busy", 64'(b0), 64'd1);
    chk("setup12_valid", 64'(v0), 64'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    start0 = 1'b0;
    chk("clr_rn", 64'(rn0), 64'd0);
    chk("clr_valid", 64'(v0), 64'd0);
    chk("clr_data", 64'(d0), 64'd0);
    chk("clr_idx", 64'(i0), 64'd0);
    chk("clr_busy", 64'(b0), 64'd0);
    chk("clr_done", 64'(dn0), 64'd0);
    step();
    chk("clr_stays_idle", 64'(b0), 64'd0);

    // Single-register configuration.
    sel = 1'b1;
    regs[5] = 32'hDEADBEEF;
    build_expected(5, 5);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    run_dump(1'b0, 50);
    step();
    chk("single_done_one_cycle", 64'(dn1), 64'd0);
    chk("single_idle", 64'(b1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
